// File: rtl/cal_pkg.sv
// ============================================================================
// Module   : cal_pkg
// Brief    : Shared widths, weekday encoding and helpers for the calendar block.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cal_pkg;

    localparam int DATE_W = 5;
    localparam int WEEK_W = 3;

    typedef enum logic [WEEK_W-1:0] {
        MON = 3'd1,
        TUE = 3'd2,
        WED = 3'd3,
        THU = 3'd4,
        FRI = 3'd5,
        SAT = 3'd6,
        SUN = 3'd7
    } weekday_e;

    localparam logic [DATE_W-1:0] LEN_MIN = 5'd28;
    localparam logic [DATE_W-1:0] LEN_MAX = 5'd31;

    function automatic logic is_weekend(input logic [WEEK_W-1:0] week);
        return (week == SAT) || (week == SUN);
    endfunction

    // Out-of-range month lengths fall back to the longest month.
    function automatic logic [DATE_W-1:0] clamp_len(input logic [DATE_W-1:0] len);
        return ((len < LEN_MIN) || (len > LEN_MAX)) ? LEN_MAX : len;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cal_wrap_counter.sv
// ============================================================================
// Module   : cal_wrap_counter
// Brief    : 1-based counter with load, enable and programmable maximum.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cal_wrap_counter #(
    parameter int             W       = 5,
    parameter logic [W-1:0]   RST_VAL = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] max_val,
    output logic [W-1:0] count,
    output logic         at_max,
    output logic         wrap
);

    // >= rather than == so a maximum that shrinks below the count still wraps.
    assign at_max = (count >= max_val);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= RST_VAL;
            wrap  <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (load) begin
                count <= load_val;
            end else if (en) begin
                if (at_max) begin
                    count <= W'(1);
                    wrap  <= 1'b1;
                end else begin
                    count <= count + W'(1);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/calendar_day_tracker.sv
// ============================================================================
// Module   : calendar_day_tracker
// Brief    : Date/weekday source with weekend flag, month wrap and workday count.
//            Define CAL_VARIABLE_MONTH_EN to add the month_len input port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module calendar_day_tracker
    import cal_pkg::*;
#(
    parameter int DAYS_PER_MONTH = 30,
    parameter int START_WEEKDAY  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              day_tick,
    input  logic              load_en,
    input  logic [DATE_W-1:0] load_date,
    input  logic [WEEK_W-1:0] load_week,
`ifdef CAL_VARIABLE_MONTH_EN
    input  logic [DATE_W-1:0] month_len,
`endif
    output logic [DATE_W-1:0] tod_out,
    output logic [WEEK_W-1:0] week_out,
    output logic              weekend_out,
    output logic [DATE_W-1:0] workdays_out,
    output logic              month_wrap,
    output logic              load_err
);

    localparam logic [WEEK_W-1:0] START_WK = WEEK_W'(START_WEEKDAY);
    localparam logic [WEEK_W-1:0] WEEK_MAX = WEEK_W'(7);
    localparam logic [DATE_W-1:0] WD_MAX   = DATE_W'(31);

    logic [DATE_W-1:0] len;
    logic              load_ok;
    logic              do_load;
    logic              do_tick;
    logic              date_at_max;
    logic              unused_week_at_max;
    logic              unused_week_wrap;

`ifdef CAL_VARIABLE_MONTH_EN
    assign len = clamp_len(month_len);
`else
    localparam logic [DATE_W-1:0] FIXED_LEN = DATE_W'(DAYS_PER_MONTH);
    assign len = clamp_len(FIXED_LEN);
`endif

    assign load_ok = (load_date != '0) && (load_date <= len) && (load_week != '0);
    assign do_load = load_en && load_ok;
    // Any load request, legal or not, swallows a concurrent tick.
    assign do_tick = day_tick && !load_en;

    cal_wrap_counter #(
        .W       (DATE_W),
        .RST_VAL (DATE_W'(1))
    ) u_date (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (do_tick),
        .load     (do_load),
        .load_val (load_date),
        .max_val  (len),
        .count    (tod_out),
        .at_max   (date_at_max),
        .wrap     (month_wrap)
    );

    cal_wrap_counter #(
        .W       (WEEK_W),
        .RST_VAL (START_WK)
    ) u_week (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (do_tick),
        .load     (do_load),
        .load_val (load_week),
        .max_val  (WEEK_MAX),
        .count    (week_out),
        .at_max   (unused_week_at_max),
        .wrap     (unused_week_wrap)
    );

    assign weekend_out = is_weekend(week_out);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            workdays_out <= '0;
            load_err     <= 1'b0;
        end else begin
            load_err <= load_en && !load_ok;
            if (do_load) begin
                workdays_out <= '0;
            end else if (do_tick) begin
                // Month rollover clears the count even if the day left was a workday.
                if (date_at_max) begin
                    workdays_out <= '0;
                end else if ((week_out >= MON) && (week_out <= FRI) &&
                             (workdays_out != WD_MAX)) begin
                    workdays_out <= workdays_out + DATE_W'(1);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_calendar_day_tracker.sv
// ============================================================================
// Module   : tb_calendar_day_tracker
// Brief    : Directed and random checks of calendar_day_tracker against a model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_calendar_day_tracker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       day_tick = 1'b0;
    logic       load_en = 1'b0;
    logic [4:0] load_date = '0;
    logic [2:0] load_week = '0;
`ifdef CAL_VARIABLE_MONTH_EN
    logic [4:0] month_len = 5'd30;
`endif
    logic [4:0] tod_out;
    logic [2:0] week_out;
    logic       weekend_out;
    logic [4:0] workdays_out;
    logic       month_wrap;
    logic       load_err;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Reference state: plain integers updated from the calendar rules.
    int m_date, m_week, m_wd, m_len;
    bit m_wrap, m_err;

    calendar_day_tracker #(
        .DAYS_PER_MONTH (30),
        .START_WEEKDAY  (5)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .day_tick     (day_tick),
        .load_en      (load_en),
        .load_date    (load_date),
        .load_week    (load_week),
`ifdef CAL_VARIABLE_MONTH_EN
        .month_len    (month_len),
`endif
        .tod_out      (tod_out),
        .week_out     (week_out),
        .weekend_out  (weekend_out),
        .workdays_out (workdays_out),
        .month_wrap   (month_wrap),
        .load_err     (load_err)
    );

    always #5 clk = ~clk;

    function automatic int cur_len();
`ifdef CAL_VARIABLE_MONTH_EN
        if (month_len < 28 || month_len > 31) return 31;
        return int'(month_len);
`else
        return 30;
`endif
    endfunction

    always @(posedge clk) begin
        m_wrap = 1'b0;
        m_err  = 1'b0;
        if (!rst_n) begin
            m_date = 1;
            m_week = 5;
            m_wd   = 0;
        end else begin
            m_len = cur_len();
            if (load_en) begin
                if (load_date >= 1 && int'(load_date) <= m_len && load_week >= 1) begin
                    m_date = int'(load_date);
                    m_week = int'(load_week);
                    m_wd   = 0;
                end else begin
                    m_err = 1'b1;
                end
            end else if (day_tick) begin
                if (m_date >= m_len) begin
                    m_date = 1;
                    m_wrap = 1'b1;
                    m_wd   = 0;
                end else begin
                    m_date = m_date + 1;
                    if (m_week <= 5 && m_wd < 31) m_wd = m_wd + 1;
                end
                m_week = (m_week % 7) + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_tod",      32'(tod_out),      32'(m_date));
            check("model_week",     32'(week_out),     32'(m_week));
            check("model_weekend",  32'(weekend_out),  32'(m_week >= 6));
            check("model_workdays", 32'(workdays_out), 32'(m_wd));
            check("model_wrap",     32'(month_wrap),   32'(m_wrap));
            check("model_load_err", 32'(load_err),     32'(m_err));
        end
    end

    // Called at a negedge; applies inputs for exactly one rising edge.
    task automatic drive(input logic r, input logic t, input logic le,
                         input logic [4:0] d, input logic [2:0] w);
        rst_n     = r;
        day_tick  = t;
        load_en   = le;
        load_date = d;
        load_week = w;
        @(negedge clk);
    endtask

    task automatic pin(input string tag, input int d, input int w, input int wd,
                       input int wr, input int er);
        check({tag, "_tod"},  32'(tod_out),      32'(d));
        check({tag, "_week"}, 32'(week_out),     32'(w));
        check({tag, "_wknd"}, 32'(weekend_out),  32'(w >= 6));
        check({tag, "_wd"},   32'(workdays_out), 32'(wd));
        check({tag, "_wrap"}, 32'(month_wrap),   32'(wr));
        check({tag, "_err"},  32'(load_err),     32'(er));
    endtask

    initial begin
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 5'd9, 3'd2);
        chk_en = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 5'd0, 3'd0);
        pin("reset", 1, 5, 0, 0, 0);

        // Rollover at end of a 30-day month
        drive(1'b1, 1'b0, 1'b1, 5'd29, 3'd7);
        pin("ld29", 29, 7, 0, 0, 0);
        drive(1'b1, 1'b1, 1'b0, 5'd0, 3'd0);
        pin("roll1", 30, 1, 0, 0, 0);
        drive(1'b1, 1'b1, 1'b0, 5'd0, 3'd0);
        pin("roll2", 1, 2, 0, 1, 0);
        drive(1'b1, 1'b0, 1'b0, 5'd0, 3'd0);
        pin("roll_idle", 1, 2, 0, 0, 0);

        // One week of ticks from Monday the 1st
        drive(1'b1, 1'b0, 1'b1, 5'd1, 3'd1);
        for (int k = 1; k <= 7; k++) begin
            drive(1'b1, 1'b1, 1'b0, 5'd0, 3'd0);
            check("week_wknd", 32'(weekend_out), 32'(k == 5 || k == 6));
        end
        pin("week7", 8, 1, 5, 0, 0);

        // Illegal loads with concurrent tick are rejected and drop the tick
        drive(1'b1, 1'b1, 1'b1, 5'd0, 3'd3);
        pin("bad_date0", 8, 1, 5, 0, 1);
        drive(1'b1, 1'b1, 1'b1, 5'd12, 3'd0);
        pin("bad_week0", 8, 1, 5, 0, 1);
        drive(1'b1, 1'b0, 1'b1, 5'd31, 3'd4);
        pin("bad_date31", 8, 1, 5, 0, 1);
        drive(1'b1, 1'b0, 1'b0, 5'd0, 3'd0);
        pin("err_idle", 8, 1, 5, 0, 0);

        // Legal load wins over a same-cycle tick
        drive(1'b1, 1'b1, 1'b0, 5'd0, 3'd0);
        drive(1'b1, 1'b1, 1'b1, 5'd10, 3'd3);
        pin("collide", 10, 3, 0, 0, 0);
        drive(1'b1, 1'b1, 1'b1, 5'd30, 3'd6);
        pin("ld_len", 30, 6, 0, 0, 0);

        // Reset mid-operation discards a pending tick
        drive(1'b0, 1'b1, 1'b0, 5'd0, 3'd0);
        pin("mid_rst", 1, 5, 0, 0, 0);

`ifdef CAL_VARIABLE_MONTH_EN
        month_len = 5'd31;
        drive(1'b1, 1'b0, 1'b1, 5'd31, 3'd3);
        pin("ld31", 31, 3, 0, 0, 0);
        month_len = 5'd30;
        drive(1'b1, 1'b1, 1'b0, 5'd0, 3'd0);
        pin("shrink", 1, 4, 0, 1, 0);
        month_len = 5'd5;
        drive(1'b1, 1'b0, 1'b1, 5'd31, 3'd2);
        pin("clamp_ld", 31, 2, 0, 0, 0);
`endif

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic r, t, le;
            logic [4:0] d;
            logic [2:0] w;
            r  = ($urandom_range(0, 99) != 0);
            t  = ($urandom_range(0, 99) < 65);
            le = ($urandom_range(0, 99) < 6);
            d  = 5'($urandom_range(0, 31));
            w  = 3'($urandom_range(0, 7));
`ifdef CAL_VARIABLE_MONTH_EN
            month_len = 5'($urandom_range(26, 31));
`endif
            drive(r, t, le, d, w);
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
